// File: rtl/decoder_tx_arbiter.sv
// decoder_tx_arbiter: round-robin share of the serial transmitter among N_CH decoder channels,
// each with a one-entry capture slot and a handshake on the transmitter's reset_decoder pulse.
module decoder_tx_arbiter #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 17,
    parameter int TS_W   = 24,
    parameter int CH_W   = 2
) (
    input  logic                   clk_12MHz,
    input  logic                   rst,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH*TS_W-1:0]   ch_timestamp,
    output logic [N_CH-1:0]        ch_ack,
    output logic                   tx_data_availible,
    output logic [DATA_W-1:0]      tx_decoded_data,
    output logic [TS_W-1:0]        tx_timestamp,
    output logic [CH_W-1:0]        tx_channel,
    input  logic                   tx_reset_decoder,
    output logic [N_CH-1:0]        stall
);
    typedef enum logic [1:0] {IDLE, PRESENT, WAIT} state_t;
    state_t state, state_next;
    logic [N_CH-1:0] full, cap;
    logic [DATA_W-1:0] slot_data [N_CH];
    logic [TS_W-1:0] slot_ts [N_CH];
    logic [CH_W-1:0] last_grant, pick;
    logic found, release_slot, load;
    // An ack in flight blocks re-capture so a held ch_valid is taken only once.
    assign cap = ch_valid & ~full & ~ch_ack;
    always_comb begin
        logic [CH_W-1:0] idx;
        idx = '0;
        pick = '0;
        found = 1'b0;
        for (int j = 1; j <= N_CH; j++) begin
            idx = CH_W'((int'(last_grant) + j) % N_CH);
            if (!found && full[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end
    always_comb begin
        load = state == IDLE && found;
        release_slot = state == WAIT && tx_reset_decoder;
        state_next = load ? PRESENT : (state == PRESENT) ? WAIT : release_slot ? IDLE : state;
    end
    always_ff @(posedge clk_12MHz) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clk_12MHz) begin
        for (int i = 0; i < N_CH; i++) begin
            if (cap[i]) begin
                slot_data[i] <= ch_data[i*DATA_W +: DATA_W];
                slot_ts[i] <= ch_timestamp[i*TS_W +: TS_W];
            end
        end
    end
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            full <= '0;
            ch_ack <= '0;
            stall <= '0;
            tx_data_availible <= 1'b0;
            tx_decoded_data <= '0;
            tx_timestamp <= '0;
            tx_channel <= '0;
            last_grant <= CH_W'(N_CH - 1);
        end else begin
            ch_ack <= cap;
            // The ack cycle itself is not backpressure: the decoder has not yet seen it.
            stall <= stall | (ch_valid & full & ~ch_ack);
            for (int i = 0; i < N_CH; i++) begin
                if (cap[i]) full[i] <= 1'b1;
                else if (release_slot && tx_channel == CH_W'(i)) full[i] <= 1'b0;
            end
            if (load) begin
                tx_decoded_data <= slot_data[pick];
                tx_timestamp <= slot_ts[pick];
                tx_channel <= pick;
            end
            if (state == PRESENT) tx_data_availible <= 1'b1;
            if (release_slot) begin
                tx_data_availible <= 1'b0;
                last_grant <= tx_channel;
            end
        end
    end
endmodule

// File: tb/tb_decoder_tx_arbiter.sv
// tb_decoder_tx_arbiter: cycle-vector table for the basic handshake plus directed
// sequences for round-robin order, backpressure and reset during WAIT.
module tb_decoder_tx_arbiter;
    logic clk_12MHz = 1'b0;
    logic rst = 1'b1;
    logic [3:0] ch_valid = '0;
    logic [4*17-1:0] ch_data;
    logic [4*24-1:0] ch_timestamp;
    logic [3:0] ch_ack;
    logic tx_data_availible;
    logic [16:0] tx_decoded_data;
    logic [23:0] tx_timestamp;
    logic [1:0] tx_channel;
    logic tx_reset_decoder = 1'b0;
    logic [3:0] stall;
    logic [16:0] dat [4];
    logic [23:0] tsv [4];
    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;

    always #5 clk_12MHz = ~clk_12MHz;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ch_data[i*17 +: 17] = dat[i];
            ch_timestamp[i*24 +: 24] = tsv[i];
        end
    end

    decoder_tx_arbiter dut (
        .clk_12MHz(clk_12MHz),
        .rst(rst),
        .ch_valid(ch_valid),
        .ch_data(ch_data),
        .ch_timestamp(ch_timestamp),
        .ch_ack(ch_ack),
        .tx_data_availible(tx_data_availible),
        .tx_decoded_data(tx_decoded_data),
        .tx_timestamp(tx_timestamp),
        .tx_channel(tx_channel),
        .tx_reset_decoder(tx_reset_decoder),
        .stall(stall)
    );

    typedef struct {
        logic r;
        logic [3:0] v;
        logic d;
        logic [3:0] ack;
        logic av;
        logic [1:0] ch;
        logic [3:0] st;
        logic bus;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_12MHz);
        #1;
        ack_cnt += $countones(ch_ack);
    endtask

    task automatic serve(input logic [1:0] ch);
        for (int n = 0; n < 10 && !tx_data_availible; n++) tick();
        chk("avail_rise", 64'(tx_data_availible), 64'd1);
        chk("grant_ch", 64'(tx_channel), 64'(ch));
        chk("grant_data", 64'(tx_decoded_data), 64'(dat[ch]));
        chk("grant_ts", 64'(tx_timestamp), 64'(tsv[ch]));
        tx_reset_decoder = 1'b1;
        tick();
        tx_reset_decoder = 1'b0;
        chk("avail_fall", 64'(tx_data_availible), 64'd0);
    endtask

    initial begin
        dat = '{17'h1AAAA, 17'h01111, 17'h02222, 17'h03333};
        tsv = '{24'hAAAAAA, 24'h111111, 24'h222222, 24'h333333};
        tbl[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[2] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[3] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[4] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b1};
        tbl[5] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b1};
        tbl[6] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[7] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
        for (int k = 0; k < 8; k++) begin
            rst = tbl[k].r;
            ch_valid = tbl[k].v;
            tx_reset_decoder = tbl[k].d;
            tick();
            chk($sformatf("t%0d_ack", k), 64'(ch_ack), 64'(tbl[k].ack));
            chk($sformatf("t%0d_avail", k), 64'(tx_data_availible), 64'(tbl[k].av));
            chk($sformatf("t%0d_ch", k), 64'(tx_channel), 64'(tbl[k].ch));
            chk($sformatf("t%0d_stall", k), 64'(stall), 64'(tbl[k].st));
            if (tbl[k].bus) begin
                chk($sformatf("t%0d_data", k), 64'(tx_decoded_data), 64'(dat[tbl[k].ch]));
                chk($sformatf("t%0d_ts", k), 64'(tx_timestamp), 64'(tsv[tbl[k].ch]));
            end
        end
        tx_reset_decoder = 1'b0;
        // all channels at once, fresh priority from ch0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack_cnt = 0;
        ch_valid = 4'b1111;
        tick();
        chk("all_ack", 64'(ch_ack), 64'hF);
        ch_valid = '0;
        for (int c = 0; c < 4; c++) serve(2'(c));
        chk("all_ack_count", 64'(ack_cnt), 64'd4);
        // round-robin continues after ch2
        ch_valid = 4'b0100;
        tick();
        chk("rr_ack2", 64'(ch_ack), 64'b0100);
        ch_valid = '0;
        serve(2'd2);
        ch_valid = 4'b1001;
        tick();
        chk("rr_ack03", 64'(ch_ack), 64'b1001);
        ch_valid = '0;
        serve(2'd3);
        serve(2'd0);
        // held valid while slot 1 is presented
        ch_valid = 4'b0010;
        tick();
        chk("bp_ack", 64'(ch_ack), 64'b0010);
        ack_cnt = 0;
        tick();
        tick();
        chk("bp_stall", 64'(stall), 64'b0010);
        for (int n = 0; n < 10 && !tx_data_availible; n++) tick();
        chk("bp_ch", 64'(tx_channel), 64'd1);
        chk("bp_data", 64'(tx_decoded_data), 64'h01111);
        dat[1] = 17'h1FFFF;
        tick();
        tick();
        chk("bp_no_reack", 64'(ack_cnt), 64'd0);
        tx_reset_decoder = 1'b1;
        tick();
        tx_reset_decoder = 1'b0;
        chk("bp_free_avail", 64'(tx_data_availible), 64'd0);
        chk("bp_free_noack", 64'(ch_ack), 64'd0);
        tick();
        chk("bp_reack", 64'(ch_ack), 64'b0010);
        ch_valid = '0;
        for (int n = 0; n < 10 && !tx_data_availible; n++) tick();
        chk("bp_new_data", 64'(tx_decoded_data), 64'h1FFFF);
        chk("bp_new_ch", 64'(tx_channel), 64'd1);
        // reset while waiting on the transmitter
        chk("pre_rst_avail", 64'(tx_data_availible), 64'd1);
        rst = 1'b1;
        ch_valid = 4'b0011;
        tick();
        chk("rst_avail", 64'(tx_data_availible), 64'd0);
        chk("rst_ack", 64'(ch_ack), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ack", 64'(ch_ack), 64'b0011);
        ch_valid = '0;
        serve(2'd0);
        serve(2'd1);
        chk("end_stall", 64'(stall), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
